// File: rtl/reset_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : reset_pkg
// Description : Shared types and constants for the reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } rst_seq_state_t;

    localparam int MIN_SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/rst_sync_chain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rst_sync_chain
// Description : Multi-flop synchroniser with async preset/clear to RESET_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [STAGES-1:0] r_stages;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stages <= {STAGES{RESET_VAL}};
        end else begin
            r_stages <= {r_stages[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stages[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : reset_sequencer
// Description : Lock-gated, staggered multi-domain reset release sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_DOMAINS = 3,
    parameter int STAGE_GAP   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lock_i,
    input  logic                   soft_rst_req,
    output logic [NUM_DOMAINS-1:0] domain_rst_o,
    output logic                   all_released,
    output logic [1:0]             state_o
);

    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int c_GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int c_IDX_W  = $clog2(NUM_DOMAINS + 1);

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(STAGE_GAP - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(NUM_DOMAINS - 1);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_chk_sync
        $error("reset_sequencer: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_chk_dom
        $error("reset_sequencer: NUM_DOMAINS must be in 1..8");
    end
    if (STAGE_GAP < 1) begin : g_chk_gap
        $error("reset_sequencer: STAGE_GAP must be >= 1");
    end

    logic w_rst_sync;
    logic w_lock_sync;

    rst_sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_rst_sync (
        .clk (clk),
        .rst (rst),
        .i_d (1'b0),
        .o_q (w_rst_sync)
    );

    rst_sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (lock_i),
        .o_q (w_lock_sync)
    );

    rst_seq_state_t           r_state,        w_state_nxt;
    logic [c_HOLD_W-1:0]      r_hold_cnt,     w_hold_nxt;
    logic [c_GAP_W-1:0]       r_gap_cnt,      w_gap_nxt;
    logic [c_IDX_W-1:0]       r_idx,          w_idx_nxt;
    logic [NUM_DOMAINS-1:0]   r_domain_rst,   w_dom_nxt;
    logic                     r_all_released, w_all_nxt;
    logic [c_IDX_W-1:0]       w_idx_inc;
    logic                     w_reentry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= SYNC;
            r_hold_cnt     <= '0;
            r_gap_cnt      <= '0;
            r_idx          <= '0;
            r_domain_rst   <= '1;
            r_all_released <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_hold_cnt     <= w_hold_nxt;
            r_gap_cnt      <= w_gap_nxt;
            r_idx          <= w_idx_nxt;
            r_domain_rst   <= w_dom_nxt;
            r_all_released <= w_all_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_idx_nxt   = r_idx;
        w_dom_nxt   = r_domain_rst;
        w_all_nxt   = r_all_released;
        w_idx_inc   = r_idx + 1'b1;
        // Re-entry outranks every normal transition, including the last release.
        w_reentry   = (r_state != SYNC) &&
                      (soft_rst_req || (!w_lock_sync && (r_state == RELEASE || r_state == RUN)));

        if (w_reentry) begin
            w_state_nxt = HOLD;
            w_hold_nxt  = '0;
            w_gap_nxt   = '0;
            w_idx_nxt   = '0;
            w_dom_nxt   = '1;
            w_all_nxt   = 1'b0;
        end else begin
            case (r_state)
                SYNC: begin
                    if (!w_rst_sync) begin
                        w_state_nxt = HOLD;
                        w_hold_nxt  = '0;
                    end
                end
                HOLD: begin
                    if (!w_lock_sync) begin
                        w_hold_nxt = '0;
                    end else if (r_hold_cnt == c_HOLD_LAST) begin
                        w_dom_nxt[0] = 1'b0;
                        w_hold_nxt   = '0;
                        if (NUM_DOMAINS == 1) begin
                            w_state_nxt = RUN;
                            w_all_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = RELEASE;
                            w_idx_nxt   = '0;
                            w_gap_nxt   = '0;
                        end
                    end else begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        w_gap_nxt = '0;
                        w_idx_nxt = w_idx_inc;
                        for (int k = 1; k < NUM_DOMAINS; k++) begin
                            if (w_idx_inc == c_IDX_W'(k)) begin
                                w_dom_nxt[k] = 1'b0;
                            end
                        end
                        if (w_idx_inc == c_IDX_LAST) begin
                            w_state_nxt = RUN;
                            w_all_nxt   = 1'b1;
                        end
                    end else begin
                        w_gap_nxt = r_gap_cnt + 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    w_state_nxt = SYNC;
                end
            endcase
        end
    end

    assign domain_rst_o = r_domain_rst;
    assign all_released = r_all_released;
    assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Self-checking bench, three parameter sets against a timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    logic clk;
    logic rst;
    logic lock_i;
    logic soft_rst_req;
    logic cmp_en;

    logic [23:0] dom_flat;
    logic [2:0]  ar_flat;
    logic [5:0]  st_flat;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // cfg0: defaults; cfg1: single fast domain; cfg2: eight domains, 1-cycle gap
    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int S = (g == 1) ? 3 : 2;
        localparam int H = (g == 0) ? 16 : ((g == 1) ? 1 : 4);
        localparam int N = (g == 0) ? 3 : ((g == 1) ? 1 : 8);
        localparam int G = (g == 0) ? 4 : 1;

        logic [N-1:0] dom;
        logic         ar;
        logic [1:0]   st;

        reset_sequencer #(
            .SYNC_STAGES (S),
            .HOLD_CYCLES (H),
            .NUM_DOMAINS (N),
            .STAGE_GAP   (G)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .lock_i       (lock_i),
            .soft_rst_req (soft_rst_req),
            .domain_rst_o (dom),
            .all_released (ar),
            .state_o      (st)
        );

        assign dom_flat[g*8 +: 8] = 8'(dom);
        assign ar_flat[g]         = ar;
        assign st_flat[g*2 +: 2]  = st;

        // Model: mode 0 = waiting out the synchroniser, 1 = holding for lock,
        // 2 = released; domain k is free once k*G cycles have elapsed in mode 2.
        int           m_mode, m_edges, m_run, m_since;
        logic [S-1:0] m_lq;

        always @(posedge clk or posedge rst) begin : p_model
            int   n_mode, n_edges, n_run, n_since;
            logic ls;
            if (rst) begin
                m_mode  <= 0;
                m_edges <= 0;
                m_run   <= 0;
                m_since <= 0;
                m_lq    <= '0;
            end else begin
                ls      = m_lq[S-1];
                n_mode  = m_mode;
                n_edges = m_edges;
                n_run   = m_run;
                n_since = m_since;
                if (m_mode == 0) begin
                    if (m_edges >= S) begin
                        n_mode = 1;
                        n_run  = 0;
                    end else begin
                        n_edges = m_edges + 1;
                    end
                end else if (soft_rst_req || (m_mode == 2 && !ls)) begin
                    n_mode  = 1;
                    n_run   = 0;
                    n_since = 0;
                end else if (m_mode == 1) begin
                    if (!ls) begin
                        n_run = 0;
                    end else if (m_run == H - 1) begin
                        n_mode  = 2;
                        n_since = 0;
                    end else begin
                        n_run = m_run + 1;
                    end
                end else begin
                    n_since = (m_since < 100000) ? m_since + 1 : m_since;
                end
                m_mode  <= n_mode;
                m_edges <= n_edges;
                m_run   <= n_run;
                m_since <= n_since;
                m_lq    <= {m_lq[S-2:0], lock_i};
            end
        end

        always @(negedge clk) begin : p_cmp
            logic [7:0] e_dom;
            logic       e_ar;
            logic [1:0] e_st;
            if (cmp_en) begin
                e_dom = 8'h00;
                for (int k = 0; k < N; k++) begin
                    e_dom[k] = !(m_mode == 2 && m_since >= k * G);
                end
                e_ar = (m_mode == 2 && m_since >= (N - 1) * G);
                e_st = (m_mode == 0) ? 2'd0 : (m_mode == 1) ? 2'd1 : (e_ar ? 2'd3 : 2'd2);
                check($sformatf("cfg%0d_model_dom", g), 32'(dom_flat[g*8 +: 8]), 32'(e_dom));
                check($sformatf("cfg%0d_model_all", g), 32'(ar), 32'(e_ar));
                check($sformatf("cfg%0d_model_state", g), 32'(st), 32'(e_st));
            end
        end
    end

    initial begin
        rst          = 1'b1;
        lock_i       = 1'b1;
        soft_rst_req = 1'b0;
        cmp_en       = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("reset_dom0", 32'(dom_flat[2:0]), 32'h7);
        check("reset_dom2", 32'(dom_flat[23:16]), 32'hFF);
        check("reset_all", 32'(ar_flat), 32'h0);
        check("reset_state", 32'(st_flat), 32'h0);

        // Power-on with lock already high
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (e == 2)  check("pwr_st_e2", 32'(st_flat[1:0]), 32'd0);
            if (e == 3)  check("pwr_st_e3", 32'(st_flat[1:0]), 32'd1);
            if (e == 18) check("pwr_dom_e18", 32'(dom_flat[2:0]), 32'h7);
            if (e == 19) check("pwr_dom_e19", 32'(dom_flat[2:0]), 32'h6);
            if (e == 19) check("pwr_st_e19", 32'(st_flat[1:0]), 32'd2);
            if (e == 22) check("pwr_dom_e22", 32'(dom_flat[2:0]), 32'h6);
            if (e == 23) check("pwr_dom_e23", 32'(dom_flat[2:0]), 32'h4);
            if (e == 26) check("pwr_all_e26", 32'(ar_flat[0]), 32'd0);
            if (e == 27) check("pwr_dom_e27", 32'(dom_flat[2:0]), 32'h0);
            if (e == 27) check("pwr_all_e27", 32'(ar_flat[0]), 32'd1);
            if (e == 27) check("pwr_st_e27", 32'(st_flat[1:0]), 32'd3);
            if (e == 4)  check("c1_dom_e4", 32'(dom_flat[8]), 32'd1);
            if (e == 5)  check("c1_dom_e5", 32'(dom_flat[8]), 32'd0);
            if (e == 5)  check("c1_all_e5", 32'(ar_flat[1]), 32'd1);
            if (e == 6)  check("c2_dom_e6", 32'(dom_flat[23:16]), 32'hFF);
            if (e == 7)  check("c2_dom_e7", 32'(dom_flat[23:16]), 32'hFE);
            if (e == 10) check("c2_dom_e10", 32'(dom_flat[23:16]), 32'hF0);
            if (e == 13) check("c2_all_e13", 32'(ar_flat[2]), 32'd0);
            if (e == 14) check("c2_dom_e14", 32'(dom_flat[23:16]), 32'h00);
            if (e == 14) check("c2_all_e14", 32'(ar_flat[2]), 32'd1);
        end

        // Soft reset in RUN, then soft request colliding with the final release
        @(negedge clk);
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        check("soft_dom", 32'(dom_flat[2:0]), 32'h7);
        check("soft_all", 32'(ar_flat[0]), 32'd0);
        check("soft_state", 32'(st_flat[1:0]), 32'd1);
        for (int r = 1; r <= 23; r++) begin
            @(posedge clk);
            #1;
            if (r == 15) check("soft_dom_r15", 32'(dom_flat[2:0]), 32'h7);
            if (r == 16) check("soft_dom_r16", 32'(dom_flat[2:0]), 32'h6);
            if (r == 20) check("soft_dom_r20", 32'(dom_flat[2:0]), 32'h4);
        end
        @(negedge clk);
        soft_rst_req = 1'b1;
        @(posedge clk);
        #1;
        check("coll_dom", 32'(dom_flat[2:0]), 32'h7);
        check("coll_all", 32'(ar_flat[0]), 32'd0);
        check("coll_state", 32'(st_flat[1:0]), 32'd1);
        @(negedge clk);
        soft_rst_req = 1'b0;

        // Lock gating: lock low through reset exit, rises 30 cycles later
        rst    = 1'b1;
        lock_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        lock_i = 1'b1;
        for (int l = 1; l <= 18; l++) begin
            @(posedge clk);
            #1;
            if (l == 1)  check("lock_st_l1", 32'(st_flat[1:0]), 32'd1);
            if (l == 17) check("lock_dom_l17", 32'(dom_flat[2:0]), 32'h7);
            if (l == 18) check("lock_dom_l18", 32'(dom_flat[2:0]), 32'h6);
        end
        repeat (20) @(posedge clk);

        // One-cycle lock drop during HOLD restarts the hold count
        @(negedge clk);
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        for (int r = 1; r <= 24; r++) begin
            @(posedge clk);
            #1;
            if (r == 16) check("drop_dom_r16", 32'(dom_flat[2:0]), 32'h7);
            if (r == 23) check("drop_dom_r23", 32'(dom_flat[2:0]), 32'h7);
            if (r == 24) check("drop_dom_r24", 32'(dom_flat[2:0]), 32'h6);
            if (r == 5) begin
                @(negedge clk);
                lock_i = 1'b0;
            end
            if (r == 6) begin
                @(negedge clk);
                lock_i = 1'b1;
            end
        end

        // Short asynchronous reset pulse mid-release
        repeat (2) @(posedge clk);
        #1.5;
        rst = 1'b1;
        #1;
        check("async_dom", 32'(dom_flat[2:0]), 32'h7);
        check("async_state", 32'(st_flat[1:0]), 32'd0);
        #2;
        rst = 1'b0;
        for (int e = 1; e <= 19; e++) begin
            @(posedge clk);
            #1;
            if (e == 18) check("rerun_dom_e18", 32'(dom_flat[2:0]), 32'h7);
            if (e == 19) check("rerun_dom_e19", 32'(dom_flat[2:0]), 32'h6);
        end

        // Randomised traffic, judged only by the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            soft_rst_req = ($urandom_range(0, 59) == 0);
            if (lock_i && $urandom_range(0, 49) == 0) begin
                lock_i = 1'b0;
            end else if (!lock_i && $urandom_range(0, 2) == 0) begin
                lock_i = 1'b1;
            end
            if ($urandom_range(0, 249) == 0) begin
                @(posedge clk);
                #1.5;
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
        end
        @(negedge clk);
        soft_rst_req = 1'b0;
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
